// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus scheduler.
//   - Region base/limit addresses (inclusive) for SRAM_0, SRAM_1, UART1 and
//     Control_Module.
//   - region_e: region index.
//   - state_e: scheduler FSM states.
//   - CS_*: one-hot bus_cs encodings.
//   - region_cs(): maps a region index to its one-hot select.
package mem_bus_pkg;

   localparam logic [31:0] SRAM0_BASE  = 32'h1000_0000;
   localparam logic [31:0] SRAM0_LIMIT = 32'h13FF_FFFF;
   localparam logic [31:0] SRAM1_BASE  = 32'h1400_0000;
   localparam logic [31:0] SRAM1_LIMIT = 32'h17FF_FFFF;
   localparam logic [31:0] UART1_BASE  = 32'h4802_2000;
   localparam logic [31:0] UART1_LIMIT = 32'h4802_2FFF;
   localparam logic [31:0] CTRL_BASE   = 32'h44E1_0000;
   localparam logic [31:0] CTRL_LIMIT  = 32'h44E1_1FFF;

   typedef enum logic [2:0] {
      REG_SRAM0,
      REG_SRAM1,
      REG_UART1,
      REG_CTRL,
      REG_NONE
   } region_e;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   localparam logic [3:0] CS_NONE  = 4'b0000;
   localparam logic [3:0] CS_SRAM0 = 4'b0001;
   localparam logic [3:0] CS_SRAM1 = 4'b0010;
   localparam logic [3:0] CS_UART1 = 4'b0100;
   localparam logic [3:0] CS_CTRL  = 4'b1000;

   function automatic logic [3:0] region_cs(input region_e r);
      case (r)
         REG_SRAM0: return CS_SRAM0;
         REG_SRAM1: return CS_SRAM1;
         REG_UART1: return CS_UART1;
         REG_CTRL:  return CS_CTRL;
         default:   return CS_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder for the memory-mapped bus.
//   addr : address to decode (ADDR_W bits, compared zero-extended)
//   sel  : one-hot select [0]=SRAM_0 [1]=SRAM_1 [2]=UART1 [3]=Control_Module
//   hit  : high when addr falls in any mapped region
module mem_region_decode
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [3:0]        sel,
   output logic              hit
);

   // Widen so the 32-bit map compares correctly for any ADDR_W up to 64;
   // upper address bits above 31 must be zero to hit a region.
   logic [63:0] a;
   region_e     region;

   assign a = 64'(addr);

   always_comb begin
      region = REG_NONE;
      if (a >= 64'(SRAM0_BASE) && a <= 64'(SRAM0_LIMIT))
         region = REG_SRAM0;
      else if (a >= 64'(SRAM1_BASE) && a <= 64'(SRAM1_LIMIT))
         region = REG_SRAM1;
      else if (a >= 64'(UART1_BASE) && a <= 64'(UART1_LIMIT))
         region = REG_UART1;
      else if (a >= 64'(CTRL_BASE) && a <= 64'(CTRL_LIMIT))
         region = REG_CTRL;
      sel = region_cs(region);
      hit = (region != REG_NONE);
   end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Two-master round-robin scheduler for the SRAM_0/SRAM_1/UART1/Control_Module
// bus. Each access goes IDLE -> ACCESS (WAIT+1 cycles) -> DONE; unmapped
// addresses go IDLE -> DONE with err.
//   clk, RESET          : clock, synchronous active-high reset
//   req/addr0/addr1/wr/wdata0/wdata1 : master requests (req held until done)
//   gnt, done, err, rdata : per-master grant, completion, error, read data
//   bus_addr/bus_wdata/bus_we/bus_cs/bus_rdata : slave-side bus
// Optional build macro MEM_BUS_ERR_LOG_EN adds err_irq/err_addr/err_clr, a
// sticky log of the first unmapped access since the last clear.
module mem_bus_scheduler
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 16,
   parameter int SRAM_WAIT = 1,
   parameter int IO_WAIT   = 3
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [1:0]        wr,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic [1:0]        err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_we,
   output logic [3:0]        bus_cs,
   input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_BUS_ERR_LOG_EN
   ,
   output logic              err_irq,
   output logic [ADDR_W-1:0] err_addr,
   input  logic              err_clr
`endif
);

   generate
      if (SRAM_WAIT < 0 || SRAM_WAIT > 15 || IO_WAIT < 0 || IO_WAIT > 15) begin : g_bad_wait
         $error("mem_bus_scheduler: SRAM_WAIT/IO_WAIT must be in 0..15");
      end
   endgenerate

   localparam logic [3:0] SRAM_W4 = 4'(SRAM_WAIT);
   localparam logic [3:0] IO_W4   = 4'(IO_WAIT);

   state_e            state, state_nxt;
   logic              owner;      // master currently being served
   logic              last;       // master granted most recently
   logic              wr_q;
   logic              hit_q;
   logic [3:0]        cs_q;
   logic [3:0]        cnt;
   logic              win;
   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        dec_sel;
   logic              dec_hit;
   logic [3:0]        wait_ld;
   logic [1:0]        gvec;

   // Contention goes to the master not granted last; a lone request wins.
   assign win      = (req == 2'b11) ? ~last : req[1];
   assign sel_addr = win ? addr1 : addr0;
   assign wait_ld  = (dec_sel[0] | dec_sel[1]) ? SRAM_W4 : IO_W4;
   assign gvec     = owner ? 2'b10 : 2'b01;

   mem_region_decode #(.ADDR_W(ADDR_W)) u_decode (
      .addr (sel_addr),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   always_ff @(posedge clk) begin
      if (RESET) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         cnt       <= 4'd0;
         wr_q      <= 1'b0;
         hit_q     <= 1'b0;
         cs_q      <= CS_NONE;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (|req) begin
                  owner     <= win;
                  bus_addr  <= sel_addr;
                  bus_wdata <= win ? wdata1 : wdata0;
                  wr_q      <= wr[win];
                  cs_q      <= dec_sel;
                  hit_q     <= dec_hit;
                  cnt       <= wait_ld;
                  if (!dec_hit)
                     rdata <= '0;
               end
            end
            ACCESS: begin
               // Last ACCESS cycle: capture read data; writes leave rdata alone.
               if (cnt == 4'd0) begin
                  if (!wr_q)
                     rdata <= bus_rdata;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE:    last <= owner;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      gnt       = 2'b00;
      done      = 2'b00;
      err       = 2'b00;
      bus_cs    = CS_NONE;
      bus_we    = 1'b0;
      case (state)
         IDLE: begin
            if (|req)
               state_nxt = dec_hit ? ACCESS : DONE;
         end
         ACCESS: begin
            gnt    = gvec;
            bus_cs = cs_q;
            bus_we = wr_q;
            if (cnt == 4'd0)
               state_nxt = DONE;
         end
         DONE: begin
            gnt       = gvec;
            done      = gvec;
            err       = hit_q ? 2'b00 : gvec;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MEM_BUS_ERR_LOG_EN
   logic err_set;
   assign err_set = (state == IDLE) && (|req) && !dec_hit;

   // A set in the same cycle as a clear wins and records the new address.
   always_ff @(posedge clk) begin
      if (RESET) begin
         err_irq  <= 1'b0;
         err_addr <= '0;
      end else if (err_set) begin
         err_irq <= 1'b1;
         if (!err_irq || err_clr)
            err_addr <= sel_addr;
      end else if (err_clr) begin
         err_irq  <= 1'b0;
         err_addr <= '0;
      end
   end
`endif

endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
- Two-requester scheduler for the memory-mapped bus: SRAM_0, SRAM_1, UART1 and Control_Module.
- Arbitrates requests round-robin and decodes the granted address to a one-hot region select.
- Sequences each access through a fixed per-region wait-state count, then returns read data and a done pulse to the winner.
- Sits between the command/voice-processing masters and the memory/I-O slaves.

Parameters:
ADDR_W, 32, address width
DATA_W, 16, data width
SRAM_WAIT, 1, extra wait cycles for SRAM_0/SRAM_1 accesses
IO_WAIT, 3, extra wait cycles for UART1/Control_Module accesses

Ports:
clk  in  1  system clock, all logic on posedge
RESET  in  1  synchronous, active-high reset
req  in  2  request per master (bit i = master i); held until done[i]
addr0 / addr1  in  ADDR_W  master 0/1 address
wr  in  2  per-master write enable (1=write, 0=read)
wdata0 / wdata1  in  DATA_W  master 0/1 write data
gnt  out  2  one-hot grant, high for the whole access
done  out  2  one-cycle completion pulse to the granted master
err  out  2  one-cycle pulse with done: address unmapped
rdata  out  DATA_W  read data, valid in the done cycle
bus_addr  out  ADDR_W  registered address to slaves
bus_wdata  out  DATA_W  registered write data
bus_we  out  1  write strobe during ACCESS
bus_cs  out  4  one-hot select: [0]=SRAM_0, [1]=SRAM_1, [2]=UART1, [3]=Control_Module
bus_rdata  in  DATA_W  slave read data

Behaviour:
- Address map, inclusive:
  - SRAM_0: 0x1000_0000–0x13FF_FFFF
  - SRAM_1: 0x1400_0000–0x17FF_FFFF
  - UART1: 0x4802_2000–0x4802_2FFF
  - Control_Module: 0x44E1_0000–0x44E1_1FFF
  - Any other address is unmapped.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req bit is set, pick the winner, register addr/wdata/wr, decode the region, and go to ACCESS next cycle.
  - A single request is granted directly.
  - When both request, the master not granted last wins; after reset master 0 has priority.
- ACCESS:
  - gnt and bus_cs are asserted. bus_we is high for writes only.
  - Wait counter loads SRAM_WAIT or IO_WAIT on entry, so ACCESS lasts WAIT+1 cycles.
  - rdata is captured from bus_rdata on the last ACCESS cycle; for writes rdata holds its previous value.
- Unmapped address: skip ACCESS and go IDLE→DONE. bus_cs stays 0, err[i] pulses with done[i], and rdata is 0.
- DONE:
  - done[i] is high for exactly 1 cycle, gnt is still held, and the last-grant pointer is updated.
  - Next state is IDLE. A new grant can occur no earlier than the cycle after DONE.
- Latency from a request seen in IDLE to done: WAIT+2 cycles for a mapped address, 1 cycle for an unmapped one.
- Dropping req during ACCESS does not abort; the access completes and done still pulses.
- Changing addr or wdata after grant has no effect, because both are registered.
- req of a master held high through its own DONE is treated as a new request. Round-robin still applies, so the other master wins if it is waiting.
- Reset at any cycle: state→IDLE, last-grant→master 1 (so master 0 wins first), counter cleared.
  - All outputs go to 0: gnt, done, err, rdata, bus_addr, bus_wdata, bus_we, bus_cs.
  - Any in-flight access is abandoned with no done.
- WAIT parameters are range-checked at elaboration, 0..15. The counter is 4 bits wide and does not wrap.

Optional Feature:
- Macro: MEM_BUS_ERR_LOG_EN.
- When defined, adds three ports:
  - err_irq out 1: sticky, set on any unmapped access.
  - err_addr out ADDR_W: address of the first unmapped access since the last clear.
  - err_clr in 1: clears err_irq and err_addr next cycle. If set and clear occur in the same cycle, set wins and err_addr takes the new address.
- When not defined, these ports and their registers are absent. err pulses are unchanged either way.

Decomposition:
- Package mem_bus_pkg holds:
  - region base/limit constants
  - region index enum (REG_SRAM0, REG_SRAM1, REG_UART1, REG_CTRL, REG_NONE)
  - FSM state enum
  - bus_cs one-hot constants
- One combinational sub-module, mem_region_decode: ADDR_W address in → 4-bit one-hot select plus a hit flag. It is reusable by the existing address-decode logic.

Test Plan:
1. RESET high for 2 cycles mid-ACCESS → all outputs 0 next cycle, FSM in IDLE, no done pulse.
2. Master 0 reads 0x1000_0004, bus_rdata=0xA5A5, SRAM_WAIT=1 → bus_cs=0001 for 2 cycles, done[0] and rdata=0xA5A5 at cycle 3 after req.
3. Master 1 writes 0x1234 to 0x4802_2010, IO_WAIT=3 → bus_cs=0100, bus_we=1 for 4 cycles, bus_wdata=0x1234, done[1] at cycle 5.
4. Both masters request continuously (0x1400_0000 and 0x44E1_0000) → grants alternate 0,1,0,1; bus_cs alternates 0010/1000.
5. Master 0 reads unmapped 0x2000_0000 → bus_cs stays 0, done[0] and err[0] pulse 1 cycle after req, rdata=0. With MEM_BUS_ERR_LOG_EN: err_irq=1, err_addr=0x2000_0000 until err_clr.
6. Boundary addresses 0x13FF_FFFF→SRAM_0, 0x1400_0000→SRAM_1, 0x4802_3000→unmapped, 0x44E1_1FFF→Control_Module.
